// File: rtl/seq_pkg.sv
// Shared types and ring-pointer helpers for the sequence register bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_pkg;

  typedef enum logic {
    PLAY_IDLE = 1'b0,
    PLAY_RUN  = 1'b1
  } play_state_t;

  // Advance a ring pointer by one, wrapping at depth. The explicit compare
  // keeps this correct when depth is not a power of two.
  function automatic int unsigned mod_inc(input int unsigned v, input int unsigned depth);
    return (v == depth - 32'd1) ? 32'd0 : v + 32'd1;
  endfunction

  // Ring offset: (base + off) mod depth, valid for base, off < depth.
  function automatic int unsigned mod_add(input int unsigned base, input int unsigned off,
                                          input int unsigned depth);
    int unsigned s;
    s = base + off;
    return (s >= depth) ? s - depth : s;
  endfunction

endpackage

// File: rtl/seq_playback_fsm.sv
// Playback sequencer: walks logical indices 0..length-1 as a valid/ready stream.
// Latency: pb_valid rises one cycle after an accepted start; done pulses one cycle after the final handshake.
// Backpressure: idx and pb_last hold while pb_ready is low; start is ignored while busy.
//
// Ports:
//   clk, rst       clock, async active-high reset
//   start          request playback (ignored while running)
//   clear          abort playback without a done pulse
//   length         number of stored words, frozen while busy
//   pb_ready       consumer accepts the current word
//   idx            logical index of the current word
//   busy, pb_valid high while playing
//   pb_last        current word is the final entry
//   done           one-cycle pulse at end of playback (or empty start)
module seq_playback_fsm
  import seq_pkg::*;
#(
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int LEN_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic [LEN_W-1:0]  length,
  input  logic              pb_ready,
  output logic [ADDR_W-1:0] idx,
  output logic              busy,
  output logic              pb_valid,
  output logic              pb_last,
  output logic              done
);

  play_state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PLAY_IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      pb_valid <= 1'b0;
      pb_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state    <= PLAY_IDLE;
        idx      <= '0;
        busy     <= 1'b0;
        pb_valid <= 1'b0;
        pb_last  <= 1'b0;
      end else begin
        case (state)
          PLAY_IDLE: begin
            if (start) begin
              if (length != '0) begin
                state    <= PLAY_RUN;
                idx      <= '0;
                busy     <= 1'b1;
                pb_valid <= 1'b1;
                pb_last  <= (length == LEN_W'(1));
              end else begin
                // Nothing to play: report completion straight away.
                done <= 1'b1;
              end
            end
          end
          PLAY_RUN: begin
            if (pb_ready) begin
              if (pb_last) begin
                state    <= PLAY_IDLE;
                idx      <= '0;
                busy     <= 1'b0;
                pb_valid <= 1'b0;
                pb_last  <= 1'b0;
                done     <= 1'b1;
              end else begin
                idx <= idx + ADDR_W'(1);
                // Next index idx+1 is last when idx+2 == length; since we only
                // advance when idx <= length-2, the sum always fits LEN_W.
                pb_last <= ((LEN_W'(idx) + LEN_W'(2)) == length);
              end
            end
          end
          default: state <= PLAY_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/seq_register_bank.sv
// Ordered sequence store (append / clear / random read / streamed playback), ring-buffer backed.
// Latency: rd_data one cycle after rd_addr; appends visible in length/full next cycle; playback 1 word/cycle.
// Backpressure: playback stalls on pb_ready low; appends ignored while busy; full appends dropped with overflow pulse.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   clear                       empty sequence, abort playback (highest priority)
//   wr_en, wr_data              append a word
//   rd_addr, rd_data            registered random read, 0 = oldest; 0 beyond length
//   length, full                occupancy
//   overflow                    one-cycle pulse when a full append is dropped
//   play_start, busy            start playback / playback running
//   pb_valid, pb_data, pb_last  playback stream towards the consumer
//   pb_ready                    consumer accept
//   done                        one-cycle pulse at end of playback
//
// Build option: define SEQ_WRAP_EN to make an append while full overwrite the
// oldest entry instead of being dropped.
module seq_register_bank
  import seq_pkg::*;
#(
  parameter  int DATA_WIDTH = 2,
  parameter  int DEPTH      = 32,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int LEN_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [LEN_W-1:0]      length,
  output logic                  full,
  output logic                  overflow,
  input  logic                  play_start,
  output logic                  busy,
  output logic                  pb_valid,
  output logic [DATA_WIDTH-1:0] pb_data,
  output logic                  pb_last,
  input  logic                  pb_ready,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     head;
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     pb_idx;

  logic [ADDR_W-1:0] wr_ptr_nxt;
  logic [ADDR_W-1:0] head_nxt;
  logic [ADDR_W-1:0] rd_phys;
  logic [ADDR_W-1:0] pb_phys;

  logic start_take;
  logic wr_try;
  logic append_ok;
  logic wrap_ok;
  logic drop;

  assign full = (length == LEN_W'(DEPTH));

  assign wr_ptr_nxt = ADDR_W'(mod_inc(32'(wr_ptr), DEPTH));
  assign head_nxt   = ADDR_W'(mod_inc(32'(head), DEPTH));
  assign rd_phys    = ADDR_W'(mod_add(32'(head), 32'(rd_addr), DEPTH));
  assign pb_phys    = ADDR_W'(mod_add(32'(head), 32'(pb_idx), DEPTH));

  // A start request in IDLE owns the cycle, so a same-cycle append cannot
  // change length underneath the playback that is just being launched.
  assign start_take = play_start && !busy;
  assign wr_try     = wr_en && !clear && !busy && !start_take;
  assign append_ok  = wr_try && !full;

`ifdef SEQ_WRAP_EN
  assign wrap_ok = wr_try && full;
  assign drop    = 1'b0;
`else
  assign wrap_ok = 1'b0;
  assign drop    = wr_try && full;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      head     <= '0;
      wr_ptr   <= '0;
      length   <= '0;
      overflow <= 1'b0;
      rd_data  <= '0;
    end else begin
      overflow <= drop;
      // Out-of-range reads return zero rather than stale storage.
      rd_data  <= (LEN_W'(rd_addr) < length) ? mem[rd_phys] : '0;

      if (clear) begin
        head   <= '0;
        wr_ptr <= '0;
        length <= '0;
      end else if (append_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr_nxt;
        length      <= length + LEN_W'(1);
      end else if (wrap_ok) begin
        // Overwrite the oldest word; length stays at DEPTH.
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr_nxt;
        head        <= head_nxt;
      end
    end
  end

  seq_playback_fsm #(
    .DEPTH (DEPTH)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .start    (play_start),
    .clear    (clear),
    .length   (length),
    .pb_ready (pb_ready),
    .idx      (pb_idx),
    .busy     (busy),
    .pb_valid (pb_valid),
    .pb_last  (pb_last),
    .done     (done)
  );

  // Gated so the stream reads as zero whenever nothing is offered.
  assign pb_data = pb_valid ? mem[pb_phys] : '0;

endmodule

// File: tb/tb_seq_register_bank.sv
// Directed self-checking bench for seq_register_bank at DEPTH=4, DATA_WIDTH=2.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: pb_ready driven from per-cycle tables.
module tb_seq_register_bank;

  localparam int DW    = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [LW-1:0] length;
  logic          full;
  logic          overflow;
  logic          play_start;
  logic          busy;
  logic          pb_valid;
  logic [DW-1:0] pb_data;
  logic          pb_last;
  logic          pb_ready;
  logic          done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_register_bank #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .length     (length),
    .full       (full),
    .overflow   (overflow),
    .play_start (play_start),
    .busy       (busy),
    .pb_valid   (pb_valid),
    .pb_data    (pb_data),
    .pb_last    (pb_last),
    .pb_ready   (pb_ready),
    .done       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic append(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    rst = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_data = '0; rd_addr = '0;
    play_start = 1'b0; pb_ready = 1'b0;
    repeat (2) tick();
    outs = {length, full, overflow, busy, pb_valid, pb_last, done, rd_data, pb_data};
    vectors++;
    if (outs !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b exp=0", outs);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (length !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_length got=%0d exp=0", length);
    end
  endtask

  task automatic test_fill();
    logic [DW-1:0] seq [4];
    seq[0] = 2'd3; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd0;
    for (int i = 0; i < 4; i++) append(seq[i]);
    vectors++;
    if (length !== 3'd4 || full !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_len_full got=%0d/%0d exp=4/1", length, full);
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = AW'(i);
      tick();
      vectors++;
      if (rd_data !== seq[i]) begin
        miscompares++;
        $display("FAIL fill_read[%0d] got=%0d exp=%0d", i, rd_data, seq[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_seq [4];
    logic          exp_ovf;
`ifdef SEQ_WRAP_EN
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd0; exp_seq[3] = 2'd1;
    exp_ovf = 1'b0;
`else
    exp_seq[0] = 2'd3; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2; exp_seq[3] = 2'd0;
    exp_ovf = 1'b1;
`endif
    append(2'd1);
    vectors++;
    if (overflow !== exp_ovf) begin
      miscompares++;
      $display("FAIL overflow_pulse got=%0d exp=%0d", overflow, exp_ovf);
    end
    vectors++;
    if (length !== 3'd4) begin
      miscompares++;
      $display("FAIL overflow_length got=%0d exp=4", length);
    end
    tick();
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_one_cycle got=%0d exp=0", overflow);
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = AW'(i);
      tick();
      vectors++;
      if (rd_data !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL overflow_read[%0d] got=%0d exp=%0d", i, rd_data, exp_seq[i]);
      end
    end
  endtask

  task automatic test_short_read();
    do_clear();
    vectors++;
    if (length !== 3'd0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_len_full got=%0d/%0d exp=0/0", length, full);
    end
    append(2'd3);
    append(2'd1);
    vectors++;
    if (length !== 3'd2) begin
      miscompares++;
      $display("FAIL short_length got=%0d exp=2", length);
    end
    rd_addr = 2'd3;
    tick();
    vectors++;
    if (rd_data !== 2'd0) begin
      miscompares++;
      $display("FAIL short_read_beyond got=%0d exp=0", rd_data);
    end
    rd_addr = 2'd1;
    tick();
    vectors++;
    if (rd_data !== 2'd1) begin
      miscompares++;
      $display("FAIL short_read_in got=%0d exp=1", rd_data);
    end
  endtask

  task automatic test_playback();
    logic          rdy [6];
    logic          ev  [6];
    logic [DW-1:0] ed  [6];
    logic          el  [6];
    logic          edn [6];
    rdy[0]=1; ev[0]=1; ed[0]=2'd2; el[0]=0; edn[0]=0;
    rdy[1]=0; ev[1]=1; ed[1]=2'd3; el[1]=0; edn[1]=0;
    rdy[2]=1; ev[2]=1; ed[2]=2'd3; el[2]=0; edn[2]=0;
    rdy[3]=1; ev[3]=1; ed[3]=2'd1; el[3]=1; edn[3]=0;
    rdy[4]=0; ev[4]=0; ed[4]=2'd0; el[4]=0; edn[4]=1;
    rdy[5]=1; ev[5]=0; ed[5]=2'd0; el[5]=0; edn[5]=0;
    do_clear();
    append(2'd2);
    append(2'd3);
    append(2'd1);
    pb_ready   = 1'b0;
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pb_ready = rdy[k];
      #1;
      vectors++;
      if ({pb_valid, busy, pb_data, pb_last, done} !== {ev[k], ev[k], ed[k], el[k], edn[k]}) begin
        miscompares++;
        $display("FAIL playback[%0d] got vld=%0d busy=%0d dat=%0d last=%0d done=%0d exp vld=%0d busy=%0d dat=%0d last=%0d done=%0d",
                 k, pb_valid, busy, pb_data, pb_last, done, ev[k], ev[k], ed[k], el[k], edn[k]);
      end
      tick();
    end
    pb_ready = 1'b0;
  endtask

  task automatic test_empty_start();
    do_clear();
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    vectors++;
    if (done !== 1'b1 || pb_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_start got done=%0d vld=%0d busy=%0d exp 1/0/0", done, pb_valid, busy);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || pb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_start_after got done=%0d vld=%0d exp 0/0", done, pb_valid);
    end
  endtask

  task automatic test_write_during_play();
    do_clear();
    append(2'd2);
    append(2'd3);
    pb_ready   = 1'b0;
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL wdp_busy got=%0d exp=1", busy);
    end
    append(2'd1);
    vectors++;
    if (length !== 3'd2 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL wdp_length got len=%0d ovf=%0d exp 2/0", length, overflow);
    end
    pb_ready = 1'b1;
    tick();
    tick();
    pb_ready = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wdp_done got done=%0d busy=%0d exp 1/0", done, busy);
    end
  endtask

  task automatic test_clear_mid();
    do_clear();
    append(2'd2);
    append(2'd3);
    append(2'd1);
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    pb_ready   = 1'b1;
    tick();
    clear   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 2'd2;
    tick();
    clear    = 1'b0;
    wr_en    = 1'b0;
    pb_ready = 1'b0;
    vectors++;
    if ({length, busy, pb_valid, done} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL clear_mid got len=%0d busy=%0d vld=%0d done=%0d exp 0/0/0/0", length, busy, pb_valid, done);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || length !== 3'd0) begin
      miscompares++;
      $display("FAIL clear_mid_after got done=%0d len=%0d exp 0/0", done, length);
    end
  endtask

  task automatic test_reset_mid();
    append(2'd2);
    append(2'd3);
    append(2'd1);
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || pb_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_pre got busy=%0d vld=%0d exp 1/1", busy, pb_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({length, full, overflow, busy, pb_valid, pb_last, done, rd_data, pb_data} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_mid got len=%0d busy=%0d vld=%0d last=%0d dat=%0d exp all 0",
               length, busy, pb_valid, pb_last, pb_data);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_short_read();
    test_playback();
    test_empty_start();
    test_write_during_play();
    test_clear_mid();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
